branch_hazard_unit: RTL and testbench

- Decode-stage hazard controller sitting beside the IF/ID register, directly upstream of the decode-stage branch forwarding logic.
- Detects load-use and beq-operand hazards that forwarding cannot resolve.
- Stalls PC and IF/ID, injects ID/EX bubbles, and flushes IF/ID on a taken branch.
- A small FSM holds multi-cycle stalls so that bubbles in ID/EX do not mask a pending hazard.

---
 rtl/branch_hazard_unit.sv | 112 +++++++++++
 tb/tb_branch_hazard_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/branch_hazard_unit.sv
// Decode-stage hazard controller: load-use / beq-operand stall detection, ID/EX bubbles, IF/ID flush.
// Optional saturating statistics counters are built only when HAZARD_STATS_EN is defined.
module branch_hazard_unit #(
  parameter int          REG_ADDR_W = 5,
  parameter int          STAT_W     = 16,
  parameter logic [5:0]  BEQ_OPCODE = 6'b000100,
  parameter logic [5:0]  SW_OPCODE  = 6'b101011
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [63:0]           IFIDReg,
  input  logic                  idexRegWrite,
  input  logic                  idexMemRead,
  input  logic [REG_ADDR_W-1:0] idexDestReg,
  input  logic                  exmemRegWrite,
  input  logic                  exmemMemRead,
  input  logic [REG_ADDR_W-1:0] exmemDestReg,
  input  logic                  branchTaken,
  output logic                  pcWrite,
  output logic                  ifidWrite,
  output logic                  idexBubble,
  output logic                  ifidFlush,
  output logic                  stallActive,
  output logic [STAT_W-1:0]     stallCycles,
  output logic [STAT_W-1:0]     flushCount
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t      state;
  logic [1:0]  rem;

  logic [5:0]            opcode;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic                  is_beq;
  logic                  use_rt;
  logic                  hit_idex;
  logic                  hit_exmem;
  logic                  need2;
  logic                  need1;
  logic                  stalling;

  // PC+4 and the low instruction bits never influence hazard decisions.
  logic unused_fields;
  assign unused_fields = ^{IFIDReg[63:32], IFIDReg[15:0]};

  assign opcode = IFIDReg[31:26];
  assign rs     = REG_ADDR_W'(IFIDReg[25:21]);
  assign rt     = REG_ADDR_W'(IFIDReg[20:16]);
  assign is_beq = (opcode == BEQ_OPCODE);
  assign use_rt = (opcode == 6'b000000) || (opcode == SW_OPCODE) || is_beq;

  // Register 0 is hardwired, so it never creates a dependence; rt is masked when not read.
  assign hit_idex  = ((rs != '0) && (rs == idexDestReg)) ||
                     (use_rt && (rt != '0) && (rt == idexDestReg));
  assign hit_exmem = ((rs != '0) && (rs == exmemDestReg)) ||
                     (use_rt && (rt != '0) && (rt == exmemDestReg));

  assign need2 = is_beq && hit_idex && idexRegWrite && idexMemRead;
  assign need1 = (is_beq && hit_idex && idexRegWrite && !idexMemRead) ||
                 (is_beq && hit_exmem && exmemRegWrite && exmemMemRead) ||
                 (!is_beq && hit_idex && idexMemRead);

  assign stalling = !reset && ((state == STALL) || need2 || need1);

  assign pcWrite     = !stalling;
  assign ifidWrite   = !stalling;
  assign idexBubble  = stalling;
  assign ifidFlush   = !reset && (state == RUN) && !need2 && !need1 && is_beq && branchTaken;
  assign stallActive = !reset && (state == STALL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      rem   <= 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (need2) begin
            state <= STALL;
            rem   <= 2'd1;
          end
        end
        STALL: begin
          rem <= rem - 2'd1;
          if (rem == 2'd1) state <= RUN;
        end
        default: begin
          state <= RUN;
          rem   <= 2'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCycles <= '0;
      flushCount  <= '0;
    end else begin
      if (!pcWrite && (stallCycles != {STAT_W{1'b1}})) stallCycles <= stallCycles + 1'b1;
      if (ifidFlush && (flushCount != {STAT_W{1'b1}}))  flushCount  <= flushCount + 1'b1;
    end
  end
`else
  assign stallCycles = '0;
  assign flushCount  = '0;
`endif

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Directed bench for branch_hazard_unit: single-cycle vector table plus multi-cycle sequences.
// Counter checks expect live counts when HAZARD_STATS_EN is defined, zero otherwise.
module tb_branch_hazard_unit;

  localparam int SW_STAT = 2;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic [63:0]        ifid_reg;
  logic               idex_rw, idex_mr, exmem_rw, exmem_mr, branch_taken;
  logic [4:0]         idex_dst, exmem_dst;
  logic               pc_write, ifid_write, idex_bubble, ifid_flush, stall_active;
  logic [SW_STAT-1:0] stall_cycles, flush_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_hazard_unit #(.REG_ADDR_W(5), .STAT_W(SW_STAT)) dut (
    .clk(clk), .reset(reset), .IFIDReg(ifid_reg),
    .idexRegWrite(idex_rw), .idexMemRead(idex_mr), .idexDestReg(idex_dst),
    .exmemRegWrite(exmem_rw), .exmemMemRead(exmem_mr), .exmemDestReg(exmem_dst),
    .branchTaken(branch_taken), .pcWrite(pc_write), .ifidWrite(ifid_write),
    .idexBubble(idex_bubble), .ifidFlush(ifid_flush), .stallActive(stall_active),
    .stallCycles(stall_cycles), .flushCount(flush_count)
  );

  typedef struct {
    logic [31:0] instr;
    logic        irw, imr;
    logic [4:0]  idst;
    logic        erw, emr;
    logic [4:0]  edst;
    logic        bt;
    logic        pc, bub, fl;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt(input int n);
    if (!STATS) return 16'd0;
    return (n > 3) ? 16'd3 : 16'(n);
  endfunction

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, 16'h0};
  endfunction

  task automatic drive(input vec_t v);
    ifid_reg     = {32'hxxxx_xxxx, v.instr};
    idex_rw      = v.irw;  idex_mr  = v.imr;  idex_dst  = v.idst;
    exmem_rw     = v.erw;  exmem_mr = v.emr;  exmem_dst = v.edst;
    branch_taken = v.bt;
  endtask

  task automatic drive_clean(input logic [31:0] instr, input logic bt);
    ifid_reg = {32'h0000_0004, instr};
    idex_rw = 1'b0; idex_mr = 1'b0; idex_dst = 5'd0;
    exmem_rw = 1'b0; exmem_mr = 1'b0; exmem_dst = 5'd0;
    branch_taken = bt;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic pc, input logic bub, input logic fl, input logic sa);
    check({tag, " pcWrite"},     {15'd0, pc_write},     {15'd0, pc});
    check({tag, " ifidWrite"},   {15'd0, ifid_write},   {15'd0, pc});
    check({tag, " idexBubble"},  {15'd0, idex_bubble},  {15'd0, bub});
    check({tag, " ifidFlush"},   {15'd0, ifid_flush},   {15'd0, fl});
    check({tag, " stallActive"}, {15'd0, stall_active}, {15'd0, sa});
  endtask

  task automatic check_cnts(input string tag, input int sc, input int fc);
    check({tag, " stallCycles"}, {14'd0, stall_cycles}, exp_cnt(sc));
    check({tag, " flushCount"},  {14'd0, flush_count},  exp_cnt(fc));
  endtask

  initial begin
    // instr, idex rw/mr/dst, exmem rw/mr/dst, bt, expected pc/bubble/flush
    vecs[0]  = '{enc(6'b000100, 5'd2, 5'd3), 1, 1, 5'd2, 0, 0, 5'd0, 0, 0, 1, 0}; // beq after lw: N=2
    vecs[1]  = '{enc(6'b000100, 5'd1, 5'd4), 1, 0, 5'd4, 0, 0, 5'd0, 1, 0, 1, 0}; // beq after add, taken ignored
    vecs[2]  = '{enc(6'b000000, 5'd5, 5'd7), 1, 1, 5'd5, 0, 0, 5'd0, 0, 0, 1, 0}; // add after lw
    vecs[3]  = '{enc(6'b000000, 5'd0, 5'd7), 1, 1, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0}; // dest 0 never matches
    vecs[4]  = '{enc(6'b000100, 5'd3, 5'd3), 0, 0, 5'd0, 0, 0, 5'd0, 1, 1, 0, 1}; // taken beq, no hazard
    vecs[5]  = '{enc(6'b000100, 5'd1, 5'd2), 0, 0, 5'd0, 1, 1, 5'd2, 0, 0, 1, 0}; // beq after lw in EX/MEM
    vecs[6]  = '{enc(6'b000100, 5'd1, 5'd2), 0, 0, 5'd0, 1, 0, 5'd2, 0, 1, 0, 0}; // EX/MEM ALU result forwards
    vecs[7]  = '{{6'b100011, 5'd9, 5'bxxxxx, 16'h0}, 1, 1, 5'd8, 0, 0, 5'd0, 0, 1, 0, 0}; // lw: rt not read
    vecs[8]  = '{enc(6'b101011, 5'd9, 5'd8), 1, 1, 5'd8, 0, 0, 5'd0, 0, 0, 1, 0}; // sw reads rt
    vecs[9]  = '{enc(6'b000000, 5'd5, 5'd7), 1, 0, 5'd5, 0, 0, 5'd0, 0, 1, 0, 0}; // ALU-ALU forwards
    vecs[10] = '{enc(6'b000100, 5'd6, 5'd7), 0, 1, 5'd6, 0, 0, 5'd0, 0, 1, 0, 0}; // beq needs RegWrite
    vecs[11] = '{enc(6'b001000, 5'd1, 5'd5), 1, 1, 5'd1, 0, 0, 5'd0, 0, 0, 1, 0}; // addi rs after lw
    vecs[12] = '{enc(6'b000000, 5'd1, 5'd2), 0, 0, 5'd0, 0, 0, 5'd0, 1, 1, 0, 0}; // non-beq ignores taken

    // Reset cycle overrides a live hazard.
    reset = 1'b1;
    drive(vecs[0]);
    @(negedge clk);
    check_outs("reset", 1, 0, 0, 0);
    next_cycle();
    @(negedge clk);
    check_cnts("reset", 0, 0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      do_reset();
      drive(vecs[i]);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i].pc, vecs[i].bub, vecs[i].fl, 1'b0);
      next_cycle();
      check_cnts($sformatf("vec%0d", i), vecs[i].pc ? 0 : 1, vecs[i].fl ? 1 : 0);
    end

    // N=2: two stalled cycles, STALL ignores inputs, RUN resumes and resolves the branch.
    do_reset();
    drive(vecs[0]);
    @(negedge clk);
    check_outs("n2 c1", 0, 1, 0, 0);
    next_cycle();
    drive_clean(enc(6'b000100, 5'd2, 5'd3), 1'b1);
    @(negedge clk);
    check_outs("n2 c2", 0, 1, 0, 1);
    next_cycle();
    @(negedge clk);
    check_outs("n2 c3", 1, 0, 1, 0);
    next_cycle();
    check_cnts("n2 end", 2, 1);

    // N=1 then taken branch flushes once.
    do_reset();
    drive(vecs[1]);
    @(negedge clk);
    check_outs("n1 c1", 0, 1, 0, 0);
    next_cycle();
    drive_clean(enc(6'b000100, 5'd1, 5'd4), 1'b1);
    @(negedge clk);
    check_outs("n1 c2", 1, 0, 1, 0);
    next_cycle();
    drive_clean(32'h0, 1'b0);
    @(negedge clk);
    check_outs("n1 c3", 1, 0, 0, 0);
    check_cnts("n1 end", 1, 1);

    // Reset in the second cycle of an N=2 stall.
    do_reset();
    drive(vecs[0]);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check_outs("rst mid", 1, 0, 0, 0);
    next_cycle();
    reset = 1'b0;
    drive_clean(32'h0, 1'b0);
    @(negedge clk);
    check_outs("rst after", 1, 0, 0, 0);
    check_cnts("rst after", 0, 0);

    // Five consecutive stall cycles saturate a 2-bit counter.
    do_reset();
    drive(vecs[2]);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check_outs($sformatf("sat c%0d", c), 0, 1, 0, 0);
      next_cycle();
      check_cnts($sformatf("sat c%0d", c), c, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
